uart_tx_frame_ctrl: RTL and testbench

Parametrised UART transmit frame controller that serialises one parallel word per frame: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, then one or two stop bits. It merges the sequencer and the registered line-output selector, with runtime parity mode and back-to-back frame support. It sits between the transmit data source and the serial pin. Its clock is the bit-rate clock: one clk cycle is one bit time.

---
 rtl/uart_tx_pkg.sv | 37 +++
 rtl/uart_tx_bit_mux.sv | 37 +++
 rtl/uart_tx_frame_ctrl.sv | 119 +++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and line constants for the UART transmit frame controller
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    SEL_IDLE,
    SEL_START,
    SEL_DATA,
    SEL_PARITY,
    SEL_STOP
  } line_sel_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  function automatic line_sel_e state_to_sel(input tx_state_e st);
    line_sel_e sel;
    sel = SEL_IDLE;
    case (st)
      START:   sel = SEL_START;
      DATA:    sel = SEL_DATA;
      PARITY:  sel = SEL_PARITY;
      STOP:    sel = SEL_STOP;
      default: sel = SEL_IDLE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_bit_mux.sv
// rtl/uart_tx_bit_mux.sv - picks the line level for the next bit time and registers it onto the pin
module uart_tx_bit_mux
  import uart_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sel_i,
  input  logic       data_bit_i,
  input  logic       parity_bit_i,
  output logic       tx_o
);

  logic line_d;
  logic line_q;

  always_comb begin
    line_d = LINE_IDLE;
    case (line_sel_e'(sel_i))
      SEL_START:  line_d = 1'b0;
      SEL_DATA:   line_d = data_bit_i;
      SEL_PARITY: line_d = parity_bit_i;
      SEL_STOP:   line_d = 1'b1;
      default:    line_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      line_q <= LINE_IDLE;
    end else begin
      line_q <= line_d;
    end
  end

  assign tx_o = line_q;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// rtl/uart_tx_frame_ctrl.sv - UART transmit frame sequencer; one clk cycle per bit time
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  ready,
  output logic                  busy,
  output logic                  tx_out
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  parity_bit;
  line_sel_e             line_sel;

  // ready depends only on registered state so upstream sees no input-to-output path
  assign ready  = (state_q == IDLE) || ((state_q == STOP) && (stop_cnt_q == STOP_LAST));
  assign accept = data_valid && ready;
  assign parity_bit = (^word_q) ^ (par_typ_q == PAR_ODD);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    word_d     = word_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;

    case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d    = par_en_q ? PARITY : STOP;
          stop_cnt_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d    = STOP;
        stop_cnt_d = 1'b0;
      end
      STOP: begin
        if (stop_cnt_q == STOP_LAST) begin
          state_d = accept ? START : IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      word_d    = p_data;
      par_en_d  = par_en;
      par_typ_d = par_typ;
    end
  end

  // The line register sits in the mux, so it is fed from the next state to stay aligned with busy
  assign line_sel = state_to_sel(state_d);
  assign busy_d   = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      word_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      word_q     <= word_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;

  uart_tx_bit_mux u_bit_mux (
    .clk          (clk),
    .rst          (rst),
    .sel_i        (line_sel),
    .data_bit_i   (word_q[bit_cnt_d]),
    .parity_bit_i (parity_bit),
    .tx_o         (tx_out)
  );

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// tb/tb_uart_tx_frame_ctrl.sv - self-checking bench for uart_tx_frame_ctrl (1 and 2 stop-bit instances)
module tb_uart_tx_frame_ctrl;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic [7:0] p_data;
  logic       par_en;
  logic       par_typ;
  logic       sel;

  logic ready1, busy1, tx1;
  logic ready2, busy2, tx2;
  logic ready_mux, busy_mux, tx_mux;

  int   errors = 0;
  int   checks = 0;
  logic exp_q[$];
  logic cap[$];
  logic cur_tx;
  logic cur_busy;
  logic accepted;

  always #5 clk = ~clk;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid & ~sel),
    .p_data     (p_data),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .ready      (ready1),
    .busy       (busy1),
    .tx_out     (tx1)
  );

  uart_tx_frame_ctrl #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid & sel),
    .p_data     (p_data),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .ready      (ready2),
    .busy       (busy2),
    .tx_out     (tx2)
  );

  assign ready_mux = sel ? ready2 : ready1;
  assign busy_mux  = sel ? busy2  : busy1;
  assign tx_mux    = sel ? tx2    : tx1;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((^d) ^ pt);
    for (int i = 0; i < (sel ? 2 : 1); i++) exp_q.push_back(1'b1);
    accepted = 1'b1;
  endtask

  // Called at a falling edge: check the current bit time, drive the next edge, advance the model.
  task automatic step(input logic dv, input logic [7:0] d, input logic pe, input logic pt,
                      input logic r);
    check_bit("tx_out", tx_mux, cur_tx);
    check_bit("busy", busy_mux, cur_busy);
    check_bit("ready", ready_mux, exp_q.size() == 0);
    if (busy_mux === 1'b1) cap.push_back(tx_mux);
    data_valid = dv;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    rst        = r;
    accepted   = 1'b0;
    if (!r) exp_q.delete();
    else if (dv && exp_q.size() == 0) push_frame(d, pe, pt);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      cur_tx   = exp_q.pop_front();
      cur_busy = 1'b1;
    end else begin
      cur_tx   = 1'b1;
      cur_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    logic [9:0] a5_seq;
    int         guard;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b1, 11};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 11};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 11};
    vecs[6] = '{8'h3C, 1'b0, 1'b1, 1'b0, 10};
    a5_seq  = 10'b1101001010;

    rst        = 1'b0;
    data_valid = 1'b0;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    sel        = 1'b0;
    accepted   = 1'b0;
    @(posedge clk);
    cur_tx   = 1'b1;
    cur_busy = 1'b0;
    @(negedge clk);

    // reset held with data_valid asserted: nothing may start
    cap.delete();
    repeat (3) step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    check_int("reset_no_frame", cap.size(), 0);

    for (int v = 0; v < 7; v++) begin
      cap.delete();
      step(1'b1, vecs[v].data, vecs[v].pe, vecs[v].pt, 1'b1);
      repeat (13) step(1'b0, vecs[v].data, vecs[v].pe, vecs[v].pt, 1'b1);
      check_int($sformatf("frame_len[%0d]", v), cap.size(), vecs[v].exp_len);
      if (vecs[v].pe)
        check_bit($sformatf("parity[%0d]", v), (cap.size() > 9) ? cap[9] : 1'bx, vecs[v].exp_par);
      if (v == 0)
        for (int i = 0; i < 10; i++)
          check_bit($sformatf("a5_bit[%0d]", i), (cap.size() > i) ? cap[i] : 1'bx, a5_seq[i]);
    end

    // mid-frame request is ignored; latched config survives input changes
    cap.delete();
    step(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 8'h3C, 1'b1, 1'b1, 1'b1);
    step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    repeat (10) step(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    check_int("ignore_len", cap.size(), 11);
    check_bit("ignore_parity", (cap.size() > 9) ? cap[9] : 1'bx, 1'b1);

    // reset while data bit 4 is on the line
    cap.delete();
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
    check_int("abort_len", cap.size(), 6);
    cap.delete();
    step(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h96, 1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
    check_int("after_abort_len", cap.size(), 10);

    // back-to-back frames on the two-stop-bit instance
    sel = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cap.delete();
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    guard = 0;
    do begin
      step(1'b1, 8'h0F, 1'b0, 1'b0, 1'b1);
      guard++;
    end while (!accepted && guard < 40);
    repeat (14) step(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    check_int("b2b_busy_cycles", cap.size(), 22);
    check_bit("b2b_second_stop", (cap.size() > 10) ? cap[10] : 1'bx, 1'b1);
    check_bit("b2b_next_start", (cap.size() > 11) ? cap[11] : 1'bx, 1'b0);
    check_bit("b2b_next_d0", (cap.size() > 12) ? cap[12] : 1'bx, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
